// File: rtl/fcvt_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fcvt_pipe
//  Description : Pipelined int32 <-> binary32 conversion unit for the FPU
//                issue path. itof: signed int32 -> binary32. ftoi: binary32
//                -> signed int32, saturating. Both round to nearest with ties
//                away from zero. Results carry the destination tag. An op
//                accepted at edge N is presented on out_* after edge N+2.
//  Revision    : 1.0 - initial release
// ============================================================================
module fcvt_pipe #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [31:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [31:0] c_INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] c_INT_MIN = 32'h8000_0000;

    // Accepted op, held raw until stage 1 decodes it
    logic             s0_valid_q;
    logic             s0_op_q;
    logic [31:0]      s0_data_q;
    logic [TAG_W-1:0] s0_tag_q;

    // Stage-1 results: sign, special-case flags, itof exponent, and the
    // magnitude to round. The LSB of s1_val is always the guard (0.5) bit.
    logic             s1_valid_q;
    logic             s1_op_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic             s1_sign_q,  s1_sign_d;
    logic             s1_zero_q,  s1_zero_d;
    logic             s1_sat_q,   s1_sat_d;
    logic [4:0]       s1_exp_q,   s1_exp_d;
    logic [32:0]      s1_val_q,   s1_val_d;

    logic             out_valid_q;
    logic [31:0]      out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q;

    logic             w_adv;
    logic [31:0]      w_mag;
    logic [4:0]       w_msb;
    logic [24:0]      w_sig;
    logic [7:0]       w_bexp;
    logic [23:0]      w_frac;
    logic [4:0]       w_sh;
    logic [24:0]      w_sig_rnd;
    logic [32:0]      w_int_rnd;
    logic [7:0]       w_exp_b;

    // Whole pipe advances unless a result is waiting on writeback
    assign w_adv     = ~out_valid_q | out_ready;
    assign in_ready  = w_adv & ~flush & ~rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

    // Stage 1: normalise (itof) or align to the integer grid (ftoi)
    always_comb begin
        s1_sign_d = s0_data_q[31];
        s1_zero_d = 1'b0;
        s1_sat_d  = 1'b0;
        s1_exp_d  = '0;
        s1_val_d  = '0;
        // itof: 0x80000000 negates to itself, which is the correct magnitude
        w_mag     = s0_data_q[31] ? (~s0_data_q + 32'd1) : s0_data_q;
        w_msb     = '0;
        for (int i = 0; i < 32; i++) begin
            if (w_mag[i]) w_msb = 5'(i);
        end
        // 24-bit significand with its guard bit below; ties-away rounding
        // never needs the sticky bits, so they are simply dropped
        w_sig     = 25'((w_mag << (5'd31 - w_msb)) >> 7);
        // ftoi: shift amount places the 0.5 weight at bit 0 of s1_val
        w_bexp    = s0_data_q[30:23];
        w_frac    = {1'b1, s0_data_q[22:0]};
        w_sh      = 5'(w_bexp - 8'd126);
        if (!s0_op_q) begin
            s1_exp_d = w_msb;
            s1_val_d = {8'b0, w_sig};
        end else if (w_bexp == 8'd255) begin
            s1_sat_d = 1'b1;
            if (|s0_data_q[22:0]) s1_sign_d = 1'b0;   // NaN saturates positive
        end else if (w_bexp >= 8'd158) begin
            s1_sat_d = 1'b1;                          // |x| >= 2^31
        end else if (w_bexp < 8'd126) begin
            s1_zero_d = 1'b1;                         // zero, denormal, |x| < 0.5
        end else if (w_sh >= 5'd23) begin
            s1_val_d = {9'b0, w_frac} << (w_sh - 5'd23);
        end else begin
            s1_val_d = {9'b0, w_frac} >> (5'd23 - w_sh);
        end
    end

    // Stage 2: round the magnitude, then apply sign, saturation and packing
    always_comb begin
        w_sig_rnd  = {1'b0, s1_val_q[24:1]} + 25'(s1_val_q[0]);
        w_int_rnd  = {1'b0, s1_val_q[32:1]} + 33'(s1_val_q[0]);
        // a carry out of the significand bumps the exponent; the mantissa
        // bits are already zero in that case
        w_exp_b    = 8'(s1_exp_q) + 8'd127 + 8'(w_sig_rnd[24]);
        out_data_d = '0;
        if (!s1_op_q) begin
            // only a zero input leaves both top significand bits clear
            if (|w_sig_rnd[24:23]) out_data_d = {s1_sign_q, w_exp_b, w_sig_rnd[22:0]};
        end else if (s1_sat_q) begin
            out_data_d = s1_sign_q ? c_INT_MIN : c_INT_MAX;
        end else if (s1_zero_q) begin
            out_data_d = '0;
        end else if (!s1_sign_q) begin
            out_data_d = (w_int_rnd > {1'b0, c_INT_MAX}) ? c_INT_MAX : w_int_rnd[31:0];
        end else begin
            out_data_d = (w_int_rnd > {1'b0, c_INT_MIN}) ? c_INT_MIN : (~w_int_rnd[31:0] + 32'd1);
        end
    end

    // Accept register: captures an op whenever in_ready is high
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_op_q    <= 1'b0;
            s0_data_q  <= '0;
            s0_tag_q   <= '0;
        end else if (flush) begin
            s0_valid_q <= 1'b0;
        end else if (w_adv) begin
            s0_valid_q <= in_valid;
            if (in_valid) begin
                s0_op_q   <= in_op;
                s0_data_q <= in_data;
                s0_tag_q  <= in_tag;
            end
        end
    end

    // Stage-1 register
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= 1'b0;
            s1_tag_q   <= '0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_sat_q   <= 1'b0;
            s1_exp_q   <= '0;
            s1_val_q   <= '0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
        end else if (w_adv) begin
            s1_valid_q <= s0_valid_q;
            if (s0_valid_q) begin
                s1_op_q   <= s0_op_q;
                s1_tag_q  <= s0_tag_q;
                s1_sign_q <= s1_sign_d;
                s1_zero_q <= s1_zero_d;
                s1_sat_q  <= s1_sat_d;
                s1_exp_q  <= s1_exp_d;
                s1_val_q  <= s1_val_d;
            end
        end
    end

    // Output register: flush drops the valid but keeps data/tag stable
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (w_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q <= out_data_d;
                out_tag_q  <= s1_tag_q;
            end
        end
    end

endmodule
`default_nettype wire
